keccak_byte_padder: RTL



---
 rtl/keccak_pkg.sv | 17 +
 rtl/keccak_byte_padder.sv | 88 ++++++++
 2 files changed

// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak rate, padding constants and padder state encoding
package keccak_pkg;

    localparam int RATE_BYTES = 72;
    localparam int RATE_BITS  = 576;

    localparam logic [7:0] PAD_BYTE_SHA3   = 8'h06;
    localparam logic [7:0] PAD_BYTE_KECCAK = 8'h01;
    localparam logic [7:0] PAD_FINAL       = 8'h80;

    typedef enum logic [1:0] {
        ABSORB,
        PAD,
        FULL
    } state_t;

endpackage

// File: rtl/keccak_byte_padder.sv
// rtl/keccak_byte_padder.sv - packs message bytes into rate blocks with multi-rate padding
module keccak_byte_padder #(
    parameter int         RATE_BYTES = keccak_pkg::RATE_BYTES,
    parameter logic [7:0] PAD_BYTE   = keccak_pkg::PAD_BYTE_SHA3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in,
    input  logic                    in_valid,
    input  logic                    is_last,
    output logic                    in_ready,
    output logic [8*RATE_BYTES-1:0] out,
    output logic                    out_ready,
    output logic                    last_block,
    input  logic                    f_ack
);
    import keccak_pkg::*;

    localparam int              CNT_W    = $clog2(RATE_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pad_first;
    logic             pad_block_pending;
    logic [7:0]       pad_byte;

    assign in_ready  = (state == ABSORB);
    assign out_ready = (state == FULL);

    // First pad slot carries the domain byte; the final slot also carries the closing bit.
    assign pad_byte = (pad_first ? PAD_BYTE : 8'h00) | ((cnt == LAST_IDX) ? PAD_FINAL : 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ABSORB;
            cnt               <= '0;
            out               <= '0;
            last_block        <= 1'b0;
            pad_first         <= 1'b0;
            pad_block_pending <= 1'b0;
        end else begin
            case (state)
                ABSORB: begin
                    if (in_valid) begin
                        out <= {out[8*RATE_BYTES-9:0], in};
                        if (cnt == LAST_IDX) begin
                            state             <= FULL;
                            last_block        <= 1'b0;
                            pad_block_pending <= is_last;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (is_last) begin
                                state     <= PAD;
                                pad_first <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    out       <= {out[8*RATE_BYTES-9:0], pad_byte};
                    pad_first <= 1'b0;
                    if (cnt == LAST_IDX) begin
                        state      <= FULL;
                        last_block <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FULL: begin
                    // An exact-fill message still owes a block made entirely of padding.
                    if (f_ack) begin
                        cnt <= '0;
                        if (pad_block_pending) begin
                            state             <= PAD;
                            pad_first         <= 1'b1;
                            pad_block_pending <= 1'b0;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                default: state <= ABSORB;
            endcase
        end
    end

endmodule
